// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: Gray/binary conversion and default geometry.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 3;
  localparam int unsigned GRAY_MAX_W  = 32;

  // Width-agnostic: callers zero-extend to GRAY_MAX_W and cast the result back.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus crossing into clk.
module fifo_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full/almost-full, fill level and sticky overflow
// for the dual-clock FIFO.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              wenable,
  input  logic              wclr_ovf,
  input  logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              woverflow
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned AF_TH = DEPTH - AF_MARGIN;

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] rq2;
  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] wlevel_next;
  logic [ADDR_W:0] full_match;
  logic            winc;
  logic            wfull_next;
  logic            waf_next;
  logic            wovf_next;

  fifo_sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr_gray),
    .q     (rq2)
  );

  // Full when the next write pointer is one lap ahead of the synced read pointer.
  always_comb begin
    winc        = wenable & ~wfull;
    wbin_next   = wbin + PW'(winc);
    wgray_next  = PW'(bin2gray(GRAY_MAX_W'(wbin_next)));
    rbin_s      = PW'(gray2bin(GRAY_MAX_W'(rq2)));
    full_match  = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
    wfull_next  = (wgray_next == full_match);
    wlevel_next = wbin_next - rbin_s;
    waf_next    = (wlevel_next >= PW'(AF_TH));
    wovf_next   = (wenable & wfull) | (woverflow & ~wclr_ovf);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= waf_next;
      wlevel       <= wlevel_next;
      woverflow    <= wovf_next;
    end
  end

  assign waddr = wbin[ADDR_W-1:0];

endmodule
